// File: rtl/drive_mixer.sv
// Differential-drive mixer: X/Y commands to per-wheel servo speeds with saturation,
// slew limiting, command-loss watchdog, image-tracking step mode and power-off stop.
module drive_mixer #(
    parameter int IN_W      = 6,
    parameter int SPD_W     = 8,
    parameter int STEP_W    = 3,
    parameter int FWD_SHIFT = 2,
    parameter int SLEW_STEP = 4,
    parameter int SLEW_DIV  = 1000,
    parameter int TIMEOUT   = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              image_mode,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   input_x,
    input  logic [IN_W-1:0]   input_y,
    output logic [SPD_W-1:0]  servo_0_speed,
    output logic [SPD_W-1:0]  servo_1_speed,
    output logic              servo_0_speed_write_en,
    output logic              servo_1_speed_write_en,
    output logic [STEP_W-1:0] servo_0_step,
    output logic [STEP_W-1:0] servo_1_step,
    output logic [1:0]        state
);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    // Mixing width wide enough that no intermediate term can wrap.
    localparam int CW = SPD_W + IN_W + FWD_SHIFT + 3;
    localparam int TW = $clog2(SLEW_DIV + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic signed [CW-1:0] CENTER    = CW'((2 ** (IN_W - 1)) - 1);
    localparam logic signed [CW-1:0] NEUTRAL_S = CW'(2 ** (SPD_W - 1));
    localparam logic signed [CW-1:0] SPD_MAX_S = CW'((2 ** SPD_W) - 1);
    localparam logic [SPD_W-1:0]     NEUTRAL   = SPD_W'(2 ** (SPD_W - 1));
    localparam logic signed [SPD_W+1:0] STEP_S = (SPD_W + 2)'(SLEW_STEP);

    logic [1:0]        next_state;
    logic              wd_expire;
    logic              tick_now;
    logic [TW-1:0]     tick_cnt;
    logic [WW-1:0]     wd_cnt;
    logic [SPD_W-1:0]  target_0, target_1;
    logic [SPD_W-1:0]  mix_0, mix_1;
    logic [STEP_W-1:0] x_hi;
    logic signed [CW-1:0] fwd, turn, raw_0, raw_1;

    function automatic logic [SPD_W-1:0] saturate(input logic signed [CW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > SPD_MAX_S)
            return '1;
        else
            return v[SPD_W-1:0];
    endfunction

    function automatic logic [SPD_W-1:0] slew(input logic [SPD_W-1:0] cur,
                                              input logic [SPD_W-1:0] tgt);
        logic signed [SPD_W+1:0] d;
        d = $signed({2'b00, tgt}) - $signed({2'b00, cur});
        if (d > STEP_S)
            return cur + SPD_W'(SLEW_STEP);
        else if (d < -STEP_S)
            return cur - SPD_W'(SLEW_STEP);
        else
            return tgt;
    endfunction

    always_comb begin
        fwd   = $signed(CW'(input_y)) - CENTER;
        turn  = $signed(CW'(input_x)) - CENTER;
        raw_0 = NEUTRAL_S + (fwd <<< FWD_SHIFT) + turn;
        raw_1 = NEUTRAL_S + (fwd <<< FWD_SHIFT) - turn;
        mix_0 = saturate(raw_0);
        mix_1 = saturate(raw_1);
        x_hi  = input_x[IN_W-1 -: STEP_W];
    end

    assign tick_now = (tick_cnt == TW'(SLEW_DIV - 1));

    always_comb begin
        next_state = state;
        wd_expire  = (wd_cnt == WW'(TIMEOUT - 1)) && !in_valid;
        if (!power) begin
            next_state = S_OFF;
        end else begin
            case (state)
                S_OFF:   next_state = image_mode ? S_TRACK : S_DRIVE;
                S_DRIVE: begin
                    if (image_mode)
                        next_state = S_TRACK;
                    else if (wd_expire)
                        next_state = S_HALT;
                end
                S_TRACK: next_state = image_mode ? S_TRACK : S_DRIVE;
                default: begin
                    if (image_mode)
                        next_state = S_TRACK;
                    else if (in_valid)
                        next_state = S_DRIVE;
                end
            endcase
        end
    end

    assign servo_0_speed_write_en = (state != S_TRACK);
    assign servo_1_speed_write_en = (state != S_TRACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_OFF;
            tick_cnt      <= '0;
            wd_cnt        <= '0;
            target_0      <= NEUTRAL;
            target_1      <= NEUTRAL;
            servo_0_speed <= NEUTRAL;
            servo_1_speed <= NEUTRAL;
            servo_0_step  <= '0;
            servo_1_step  <= '0;
        end else begin
            state    <= next_state;
            tick_cnt <= tick_now ? '0 : tick_cnt + TW'(1);

            if (state == S_DRIVE && next_state == S_DRIVE && !in_valid)
                wd_cnt <= wd_cnt + WW'(1);
            else
                wd_cnt <= '0;

            // Entry recentering wins over a strobe landing on the same edge.
            if ((next_state == S_DRIVE && (state == S_OFF || state == S_TRACK)) ||
                (next_state == S_HALT && state != S_HALT)) begin
                target_0 <= NEUTRAL;
                target_1 <= NEUTRAL;
            end else if (in_valid && next_state == S_DRIVE &&
                         (state == S_DRIVE || state == S_HALT)) begin
                target_0 <= mix_0;
                target_1 <= mix_1;
            end

            if (!power) begin
                servo_0_speed <= NEUTRAL;
                servo_1_speed <= NEUTRAL;
            end else if (tick_now && (state == S_DRIVE || state == S_HALT)) begin
                servo_0_speed <= slew(servo_0_speed, target_0);
                servo_1_speed <= slew(servo_1_speed, target_1);
            end

            if (!power) begin
                servo_0_step <= '0;
                servo_1_step <= '0;
            end else if (state == S_TRACK && in_valid && input_x != '0) begin
                servo_0_step <= x_hi;
                servo_1_step <= '1 - x_hi;
            end
        end
    end

endmodule

// File: tb/tb_drive_mixer.sv
// Bench for drive_mixer: constant-table convergence checks, hand-written corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_drive_mixer;

    localparam int SLEW_DIV = 2;
    localparam int TIMEOUT  = 16;

    logic       clk = 1'b0;
    logic       rst, power, image_mode, in_valid;
    logic [5:0] input_x, input_y;
    logic [7:0] servo_0_speed, servo_1_speed;
    logic       servo_0_speed_write_en, servo_1_speed_write_en;
    logic [2:0] servo_0_step, servo_1_step;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_state, m_t0, m_t1, m_s0, m_s1, m_tick, m_wd, m_st0, m_st1;

    drive_mixer #(
        .SLEW_DIV(SLEW_DIV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .power                 (power),
        .image_mode            (image_mode),
        .in_valid              (in_valid),
        .input_x               (input_x),
        .input_y               (input_y),
        .servo_0_speed         (servo_0_speed),
        .servo_1_speed         (servo_1_speed),
        .servo_0_speed_write_en(servo_0_speed_write_en),
        .servo_1_speed_write_en(servo_1_speed_write_en),
        .servo_0_step          (servo_0_step),
        .servo_1_step          (servo_1_step),
        .state                 (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int exp0;
        int exp1;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic int approach(input int cur, input int tgt);
        if (tgt - cur > 4)  return cur + 4;
        if (cur - tgt > 4)  return cur - 4;
        return tgt;
    endfunction

    task automatic model_step(input bit r, input bit p, input bit im, input bit v,
                              input int x, input int y);
        int  ns;
        bit  tk;
        if (r) begin
            m_state = 0; m_t0 = 128; m_t1 = 128; m_s0 = 128; m_s1 = 128;
            m_tick = 0; m_wd = 0; m_st0 = 0; m_st1 = 0;
            return;
        end
        tk = (m_tick == SLEW_DIV - 1);
        if (!p)                ns = 0;
        else if (m_state == 0) ns = im ? 2 : 1;
        else if (im)           ns = 2;
        else if (m_state == 2) ns = 1;
        else if (m_state == 1) ns = (m_wd == TIMEOUT - 1 && !v) ? 3 : 1;
        else                   ns = v ? 1 : 3;

        if (!p) begin
            m_s0 = 128; m_s1 = 128;
        end else if (tk && (m_state == 1 || m_state == 3)) begin
            m_s0 = approach(m_s0, m_t0);
            m_s1 = approach(m_s1, m_t1);
        end

        if ((ns == 1 && (m_state == 0 || m_state == 2)) || (ns == 3 && m_state != 3)) begin
            m_t0 = 128; m_t1 = 128;
        end else if (v && ns == 1 && (m_state == 1 || m_state == 3)) begin
            m_t0 = clamp(128 + 4 * (y - 31) + (x - 31));
            m_t1 = clamp(128 + 4 * (y - 31) - (x - 31));
        end

        m_wd   = (m_state == 1 && ns == 1 && !v) ? m_wd + 1 : 0;
        m_tick = tk ? 0 : m_tick + 1;

        if (!p) begin
            m_st0 = 0; m_st1 = 0;
        end else if (m_state == 2 && v && x != 0) begin
            m_st0 = x / 8;
            m_st1 = 7 - x / 8;
        end
        m_state = ns;
    endtask

    task automatic compare_model();
        check("state",  int'(state), m_state);
        check("speed0", int'(servo_0_speed), m_s0);
        check("speed1", int'(servo_1_speed), m_s1);
        check("we0",    int'(servo_0_speed_write_en), (m_state != 2) ? 1 : 0);
        check("we1",    int'(servo_1_speed_write_en), (m_state != 2) ? 1 : 0);
        check("step0",  int'(servo_0_step), m_st0);
        check("step1",  int'(servo_1_step), m_st1);
    endtask

    // One clock: drive inputs, advance model, sample DUT 1 time unit after the edge.
    task automatic cycle(input bit r, input bit p, input bit im, input bit v,
                         input int x, input int y);
        rst = r; power = p; image_mode = im; in_valid = v;
        input_x = 6'(x); input_y = 6'(y);
        model_step(r, p, im, v, x, y);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic run_drive(input int x, input int y, input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b1, 1'b0, (i % 8) == 0, x, y);
    endtask

    vec_t vecs[6];

    initial begin
        int hit;
        int prob;
        bit im_r;

        vecs[0] = '{x: 31, y: 63, exp0: 255, exp1: 255};
        vecs[1] = '{x: 62, y: 31, exp0: 159, exp1: 97};
        vecs[2] = '{x: 0,  y: 0,  exp0: 0,   exp1: 35};
        vecs[3] = '{x: 31, y: 31, exp0: 128, exp1: 128};
        vecs[4] = '{x: 63, y: 0,  exp0: 36,  exp1: 0};
        vecs[5] = '{x: 63, y: 63, exp0: 255, exp1: 224};

        // reset and power-off hold
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("off_state", int'(state), 0);
        check("off_speed0", int'(servo_0_speed), 128);
        check("off_speed1", int'(servo_1_speed), 128);
        check("off_we", int'({servo_0_speed_write_en, servo_1_speed_write_en}), 3);
        check("off_steps", int'({servo_0_step, servo_1_step}), 0);

        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        check("leave_off", int'(state), 1);

        // first ramp: 4 LSB per tick, 255 reached on tick 32
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 31, 63);
        hit = 0;
        for (int i = 1; i <= 100; i++) begin
            cycle(1'b0, 1'b1, 1'b0, (i % 8) == 0, 31, 63);
            if (hit == 0 && servo_0_speed == 8'd132) hit = i;
        end
        check("first_step_cycle_le_div", (hit >= 1 && hit <= SLEW_DIV) ? 1 : 0, 1);

        foreach (vecs[k]) begin
            run_drive(vecs[k].x, vecs[k].y, 150);
            check($sformatf("vec%0d_speed0", k), int'(servo_0_speed), vecs[k].exp0);
            check($sformatf("vec%0d_speed1", k), int'(servo_1_speed), vecs[k].exp1);
        end

        // watchdog expiry and recovery
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 63, 63);
        hit = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            if (hit == 0 && state == 2'd3) hit = i;
        end
        check("wd_halt_cycle", hit, TIMEOUT);
        for (int i = 0; i < 150; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        check("halt_state", int'(state), 3);
        check("halt_speed0", int'(servo_0_speed), 128);
        check("halt_speed1", int'(servo_1_speed), 128);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 31, 47);
        check("halt_to_drive", int'(state), 1);
        run_drive(31, 47, 150);
        check("recover_speed0", int'(servo_0_speed), 192);
        check("recover_speed1", int'(servo_1_speed), 192);

        // TRACK steps
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        check("track_state", int'(state), 2);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 40, 0);
        check("track_step0", int'(servo_0_step), 5);
        check("track_step1", int'(servo_1_step), 2);
        check("track_we", int'({servo_0_speed_write_en, servo_1_speed_write_en}), 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 0, 17);
        check("track_noobj_step0", int'(servo_0_step), 5);
        check("track_noobj_step1", int'(servo_1_step), 2);

        // mid-ramp power drop, then mid-ramp reset
        for (int pass = 0; pass < 2; pass++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            run_drive(31, 31, 40);
            hit = 0;
            for (int i = 0; i < 200 && hit == 0; i++) begin
                cycle(1'b0, 1'b1, 1'b0, (i % 8) == 0, 31, 63);
                if (servo_0_speed >= 8'd200 && servo_0_speed < 8'd255) hit = 1;
            end
            check("reach_mid_ramp", hit, 1);
            if (pass == 0) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
            else           cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
            check("drop_state", int'(state), 0);
            check("drop_speed0", int'(servo_0_speed), 128);
            check("drop_speed1", int'(servo_1_speed), 128);
            check("drop_we", int'({servo_0_speed_write_en, servo_1_speed_write_en}), 3);
            check("drop_steps", int'({servo_0_step, servo_1_step}), 0);
        end

        // randomized traffic against the model
        im_r = 1'b0;
        prob = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) prob = int'($urandom_range(0, 45));
            if ($urandom_range(0, 99) < 2) im_r = ~im_r;
            cycle($urandom_range(0, 499) == 0,
                  $urandom_range(0, 99) < 98,
                  im_r,
                  int'($urandom_range(0, 99)) < prob,
                  ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 63)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
